// File: rtl/fp_align_seq_if.sv
// -----------------------------------------------------------------------------
// fp_align_seq_if
//   Bundle of the operand/result handshake and data signals of fp_align_seq.
//
//   Handshake semantics (both channels): a transfer happens on a rising clock
//   edge where valid and ready are both high. The producer raises valid and
//   keeps its payload stable until that edge; ready may be high or low freely.
//   Input channel : in_valid / in_ready, payload a, b.
//   Output channel: out_valid / out_ready, payload aligned_result, carry_out,
//                   exponent_out, aligned_sign, sign_a, sign_b and class flags.
//
//   Modports
//     master : upstream/downstream side (drives operands and out_ready)
//     slave  : the alignment stage itself
//   fsm_state is a debug view of the controller state (IDLE=0, SETUP=1,
//   SHIFT=2, ADD=3, HOLD=4).
// -----------------------------------------------------------------------------
interface fp_align_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aligned_result;
  logic        carry_out;
  logic [7:0]  exponent_out;
  logic        aligned_sign;
  logic        sign_a;
  logic        sign_b;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic [2:0]  fsm_state;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, aligned_result, carry_out, exponent_out,
           aligned_sign, sign_a, sign_b, a_nan, b_nan, a_inf, b_inf,
           a_zero, b_zero, fsm_state
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, aligned_result, carry_out, exponent_out,
           aligned_sign, sign_a, sign_b, a_nan, b_nan, a_inf, b_inf,
           a_zero, b_zero, fsm_state
  );
endinterface

// File: rtl/fp_align_seq.sv
// -----------------------------------------------------------------------------
// fp_align_seq
//   Iterative alignment / add stage of the FP32 adder, placed directly in
//   front of the normalize stage. One operand pair is accepted at a time,
//   classified (NaN / inf / zero), the smaller mantissa is right-shifted up to
//   SHIFT_STEP bits per cycle with sticky collection, and the aligned
//   mantissas are added or subtracted. The result is presented as
//   {carry_out, aligned_result} with the hidden-bit position at bit 31.
//
//   Parameters
//     SHIFT_STEP : maximum right-shift per SHIFT cycle (1..16)
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; returns to IDLE and clears all data
//     bus   : fp_align_seq_if.slave (operand input channel, result output
//             channel, class flags, debug state)
//
//   Flow: IDLE -> SETUP -> SHIFT* -> ADD -> HOLD -> IDLE
//   Special operands (any NaN/inf/zero) skip straight from SETUP to HOLD with
//   zeroed arithmetic outputs. All outputs come from registers.
// -----------------------------------------------------------------------------
module fp_align_seq #(
  parameter int SHIFT_STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  fp_align_seq_if.slave  bus
);

  localparam logic [7:0] STEP = 8'(SHIFT_STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    ADD   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state;
  state_t state_n;

  // Captured operands
  logic [31:0] a_q;
  logic [31:0] b_q;

  // Working registers for alignment
  logic [31:0] large_m;
  logic [31:0] small_m;
  logic [7:0]  diff_q;
  logic [7:0]  exp_large;
  logic        sign_large;

  // Output registers
  logic [31:0] res_q;
  logic        carry_q;
  logic [7:0]  exp_out_q;
  logic        sign_out_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic        a_nan_q;
  logic        b_nan_q;
  logic        a_inf_q;
  logic        b_inf_q;
  logic        a_zero_q;
  logic        b_zero_q;

  // ---------------------------------------------------------------------------
  // Operand decode (used in SETUP, from the captured operands)
  // ---------------------------------------------------------------------------
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [22:0] fa;
  logic [22:0] fb;
  logic        dec_a_nan;
  logic        dec_b_nan;
  logic        dec_a_inf;
  logic        dec_b_inf;
  logic        dec_a_zero;
  logic        dec_b_zero;
  logic        dec_special;
  logic [7:0]  eff_ea;
  logic [7:0]  eff_eb;
  logic [31:0] mant_a;
  logic [31:0] mant_b;
  logic        a_is_large;
  logic [31:0] dec_large_m;
  logic [31:0] dec_small_m;
  logic [7:0]  dec_exp_large;
  logic [7:0]  dec_diff;
  logic        dec_sign_large;

  always_comb begin
    ea         = a_q[30:23];
    eb         = b_q[30:23];
    fa         = a_q[22:0];
    fb         = b_q[22:0];
    dec_a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    dec_b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    dec_a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    dec_b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    dec_a_zero = (ea == 8'h00) && (fa == 23'd0);
    dec_b_zero = (eb == 8'h00) && (fb == 23'd0);
    dec_special = dec_a_nan | dec_b_nan | dec_a_inf | dec_b_inf |
                  dec_a_zero | dec_b_zero;

    // Subnormals have no hidden bit but sit at effective exponent 1.
    eff_ea = (ea == 8'h00) ? 8'd1 : ea;
    eff_eb = (eb == 8'h00) ? 8'd1 : eb;
    mant_a = {(ea != 8'h00), fa, 8'h00};
    mant_b = {(eb != 8'h00), fb, 8'h00};

    // Ties in both exponent and mantissa resolve to A.
    a_is_large = (eff_ea > eff_eb) ||
                 ((eff_ea == eff_eb) && (mant_a >= mant_b));

    if (a_is_large) begin
      dec_large_m    = mant_a;
      dec_small_m    = mant_b;
      dec_exp_large  = eff_ea;
      dec_diff       = eff_ea - eff_eb;
      dec_sign_large = a_q[31];
    end else begin
      dec_large_m    = mant_b;
      dec_small_m    = mant_a;
      dec_exp_large  = eff_eb;
      dec_diff       = eff_eb - eff_ea;
      dec_sign_large = b_q[31];
    end
  end

  // ---------------------------------------------------------------------------
  // One shift step with sticky collection
  // ---------------------------------------------------------------------------
  logic [7:0]  step_amt;
  logic [31:0] lost_mask;
  logic [31:0] sh_small;
  logic [7:0]  sh_diff;

  always_comb begin
    step_amt  = 8'd0;
    lost_mask = 32'd0;
    sh_small  = small_m;
    sh_diff   = diff_q;
    if (diff_q >= 8'd32) begin
      // Everything falls off the end: only the sticky bit survives.
      sh_small = (small_m != 32'd0) ? 32'h1 : 32'h0;
      sh_diff  = 8'd0;
    end else begin
      step_amt  = (diff_q < STEP) ? diff_q : STEP;
      lost_mask = (32'h1 << step_amt) - 32'h1;
      // Bits shifted out are folded into bit 0 so later steps keep the sticky.
      sh_small  = (small_m >> step_amt) |
                  {31'd0, (small_m & lost_mask) != 32'd0};
      sh_diff   = diff_q - step_amt;
    end
  end

  // ---------------------------------------------------------------------------
  // Add / subtract of aligned mantissas
  // ---------------------------------------------------------------------------
  logic        eff_sub;
  logic [32:0] sum33;
  logic [31:0] sub32;

  always_comb begin
    eff_sub = sign_a_q ^ sign_b_q;
    sum33   = {1'b0, large_m} + {1'b0, small_m};
    // large_m >= small_m after alignment, so this never wraps.
    sub32   = large_m - small_m;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) state_n = SETUP;
      end
      SETUP: begin
        if (dec_special)           state_n = HOLD;
        else if (dec_diff == 8'd0) state_n = ADD;
        else                       state_n = SHIFT;
      end
      SHIFT: begin
        if (sh_diff == 8'd0) state_n = ADD;
      end
      ADD: begin
        state_n = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == HOLD);
    bus.fsm_state = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      large_m    <= 32'd0;
      small_m    <= 32'd0;
      diff_q     <= 8'd0;
      exp_large  <= 8'd0;
      sign_large <= 1'b0;
      res_q      <= 32'd0;
      carry_q    <= 1'b0;
      exp_out_q  <= 8'd0;
      sign_out_q <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      a_nan_q    <= 1'b0;
      b_nan_q    <= 1'b0;
      a_inf_q    <= 1'b0;
      b_inf_q    <= 1'b0;
      a_zero_q   <= 1'b0;
      b_zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.b;
          end
        end
        SETUP: begin
          sign_a_q <= a_q[31];
          sign_b_q <= b_q[31];
          a_nan_q  <= dec_a_nan;
          b_nan_q  <= dec_b_nan;
          a_inf_q  <= dec_a_inf;
          b_inf_q  <= dec_b_inf;
          a_zero_q <= dec_a_zero;
          b_zero_q <= dec_b_zero;
          if (dec_special) begin
            // Special operands are resolved downstream from the flags.
            res_q      <= 32'd0;
            carry_q    <= 1'b0;
            exp_out_q  <= 8'd0;
            sign_out_q <= 1'b0;
          end else begin
            large_m    <= dec_large_m;
            small_m    <= dec_small_m;
            exp_large  <= dec_exp_large;
            diff_q     <= dec_diff;
            sign_large <= dec_sign_large;
          end
        end
        SHIFT: begin
          small_m <= sh_small;
          diff_q  <= sh_diff;
        end
        ADD: begin
          exp_out_q <= exp_large;
          if (eff_sub) begin
            res_q      <= sub32;
            carry_q    <= 1'b0;
            // Exact cancellation yields +0.
            sign_out_q <= (sub32 == 32'd0) ? 1'b0 : sign_large;
          end else begin
            res_q      <= sum33[31:0];
            carry_q    <= sum33[32];
            sign_out_q <= sign_large;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.aligned_result = res_q;
  assign bus.carry_out      = carry_q;
  assign bus.exponent_out   = exp_out_q;
  assign bus.aligned_sign   = sign_out_q;
  assign bus.sign_a         = sign_a_q;
  assign bus.sign_b         = sign_b_q;
  assign bus.a_nan          = a_nan_q;
  assign bus.b_nan          = b_nan_q;
  assign bus.a_inf          = a_inf_q;
  assign bus.b_inf          = b_inf_q;
  assign bus.a_zero         = a_zero_q;
  assign bus.b_zero         = b_zero_q;

endmodule

// File: tb/tb_fp_align_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_align_seq
//   Self-checking bench for fp_align_seq. A behavioural model computes the
//   expected result word and latency for each operand pair with plain integer
//   arithmetic; expected records go through a queue and are compared against
//   the DUT when out_valid is seen. Directed cases cover the documented
//   examples, back-pressure in HOLD and a reset pulse mid-shift; the rest is
//   randomized.
// -----------------------------------------------------------------------------
module tb_fp_align_seq;

  localparam int STEP = 4;
  localparam int W    = 50;  // {flags[5:0], sign_a, sign_b, sign, exp[7:0], carry, result[31:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_align_seq_if bus();

  fp_align_seq #(.SHIFT_STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: align with a single full shift plus sticky
  // ---------------------------------------------------------------------------
  task automatic model(input logic [31:0] ta, input logic [31:0] tb,
                       output logic [W-1:0] rec, output int lat);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        an, bn, ai, bi, az, bz;
    int          xa, xb, xl, d;
    logic [63:0] ma, mb, ml, ms, sm, r;
    logic        sl, sg, cy;
    logic [31:0] res;
    ea = ta[30:23]; fa = ta[22:0];
    eb = tb[30:23]; fb = tb[22:0];
    an = (ea == 8'hFF) && (fa != 0);
    bn = (eb == 8'hFF) && (fb != 0);
    ai = (ea == 8'hFF) && (fa == 0);
    bi = (eb == 8'hFF) && (fb == 0);
    az = (ea == 8'h00) && (fa == 0);
    bz = (eb == 8'h00) && (fb == 0);
    if (an || bn || ai || bi || az || bz) begin
      rec = {an, bn, ai, bi, az, bz, ta[31], tb[31], 1'b0, 8'h00, 1'b0, 32'h0};
      lat = 2;
      return;
    end
    xa = (ea == 0) ? 1 : int'(ea);
    xb = (eb == 0) ? 1 : int'(eb);
    ma = ((ea != 0) ? 64'h8000_0000 : 64'h0) + (64'(fa) << 8);
    mb = ((eb != 0) ? 64'h8000_0000 : 64'h0) + (64'(fb) << 8);
    if (xa > xb || (xa == xb && ma >= mb)) begin
      ml = ma; ms = mb; xl = xa; d = xa - xb; sl = ta[31];
    end else begin
      ml = mb; ms = ma; xl = xb; d = xb - xa; sl = tb[31];
    end
    if (d >= 32) sm = (ms != 0) ? 64'd1 : 64'd0;
    else         sm = (ms >> d) | (((ms & ((64'd1 << d) - 1)) != 0) ? 64'd1 : 64'd0);
    if (ta[31] == tb[31]) begin
      r = ml + sm; res = r[31:0]; cy = r[32]; sg = sl;
    end else begin
      r = ml - sm; res = r[31:0]; cy = 1'b0; sg = (r == 0) ? 1'b0 : sl;
    end
    rec = {6'b0, ta[31], tb[31], sg, 8'(xl), cy, res};
    if (d == 0)       lat = 3;
    else if (d >= 32) lat = 4;
    else              lat = 3 + (d + STEP - 1) / STEP;
  endtask

  // ---------------------------------------------------------------------------
  // Output comparison against one expected record
  // ---------------------------------------------------------------------------
  task automatic check_outputs(input string tag, input logic [W-1:0] rec);
    check({tag, "_res"},   64'(bus.aligned_result), 64'(rec[31:0]));
    check({tag, "_carry"}, 64'(bus.carry_out),      64'(rec[32]));
    check({tag, "_exp"},   64'(bus.exponent_out),   64'(rec[40:33]));
    check({tag, "_sign"},  64'(bus.aligned_sign),   64'(rec[41]));
    check({tag, "_sb"},    64'(bus.sign_b),         64'(rec[42]));
    check({tag, "_sa"},    64'(bus.sign_a),         64'(rec[43]));
    check({tag, "_flags"},
          64'({bus.a_nan, bus.b_nan, bus.a_inf, bus.b_inf, bus.a_zero, bus.b_zero}),
          64'(rec[49:44]));
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one complete transaction, holding out_ready low for hold cycles
  // ---------------------------------------------------------------------------
  task automatic run_txn(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input int hold);
    logic [W-1:0] rec, got_rec;
    int           lat_e, lat_w, lat, guard;
    model(ta, tb, rec, lat_e);
    exp_q.push_back(rec);
    lat_q.push_back(lat_e);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    bus.a        = ta;
    bus.b        = tb;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_busy_ready"}, 64'(bus.in_ready), 64'd0);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    got_rec = exp_q.pop_front();
    lat_w   = lat_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(lat_w));
    check_outputs(tag, got_rec);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hold_res"},   64'(bus.aligned_result), 64'(got_rec[31:0]));
      check({tag, "_hold_meta"},
            64'({bus.carry_out, bus.exponent_out, bus.aligned_sign}),
            64'({got_rec[32], got_rec[40:33], got_rec[41]}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Random operand helpers
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rand_special();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       return {s, 8'hFF, 23'($urandom()) | 23'd1};
      1:       return {s, 8'hFF, 23'd0};
      default: return {s, 31'd0};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ta, tb;
    int          ea, eb;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  64'(bus.in_ready),       64'd1);
    check("rst_out_valid", 64'(bus.out_valid),      64'd0);
    check("rst_res",       64'(bus.aligned_result), 64'd0);
    check("rst_meta",
          64'({bus.carry_out, bus.exponent_out, bus.aligned_sign, bus.sign_a, bus.sign_b}),
          64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Documented examples
    run_txn("eq_add",    32'h3F80_0000, 32'h3F80_0000, 0);
    run_txn("diff5",     32'h3F80_0000, 32'h3D00_0000, 1);
    run_txn("cancel",    32'h3F80_0000, 32'hBF80_0000, 0);
    run_txn("diff40",    32'h3F80_0000, 32'h2B80_0000, 0);
    run_txn("a_nan",     32'h7FC0_0000, 32'h3F80_0000, 0);
    run_txn("b_inf",     32'h4000_0000, 32'hFF80_0000, 0);
    run_txn("subnorm",   32'h0000_0001, 32'h0040_0000, 0);
    run_txn("b_larger",  32'h3D00_0001, 32'hBF80_0000, 0);
    run_txn("diff32",    32'h3F80_0000, 32'h2F80_0001, 0);

    // Back-pressure: five cycles with out_ready low in HOLD
    run_txn("backpress", 32'h4120_0000, 32'h3E40_0000, 5);

    // Reset pulse while in SHIFT (diff 28 -> several shift cycles)
    bus.a        = 32'h3F80_0000;
    bus.b        = 32'h3180_0000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_state_shift", 64'(bus.fsm_state), 64'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready",  64'(bus.in_ready),       64'd1);
    check("mid_rst_out_valid", 64'(bus.out_valid),      64'd0);
    check("mid_rst_res",       64'(bus.aligned_result), 64'd0);
    check("mid_rst_flags",
          64'({bus.sign_a, bus.sign_b, bus.exponent_out}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    end
    run_txn("post_rst", 32'hC2C8_0000, 32'h4148_0000, 0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      ea = $urandom_range(0, 254);
      if ($urandom_range(0, 7) == 0) ea = 0;
      ta = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom())};
      case ($urandom_range(0, 9))
        0: tb = rand_special();
        1: tb = ta ^ 32'h8000_0000;
        2: tb = ta;
        3: tb = $urandom();
        default: begin
          eb = ea + $urandom_range(0, 80) - 40;
          if (eb < 0)   eb = 0;
          if (eb > 254) eb = 254;
          tb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom())};
        end
      endcase
      if ($urandom_range(0, 1) == 1) run_txn("rnd", ta, tb, $urandom_range(0, 3));
      else                           run_txn("rnd", tb, ta, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
